// File: rtl/debounce.sv
`timescale 1ns / 1ps
// debounce: two-flop synchroniser followed by a saturating stability counter.
// A new input level reaches clean_out only after it has held unchanged for
// COUNT_MAX consecutive synchronised cycles. Any change restarts the timing.
module debounce #(
  parameter int CLK_PERIOD_NS    = 10,
  parameter int DEBOUNCE_TIME_MS = 5
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic bouncey_in,
  output logic clean_out
);

  // Stable-cycle threshold and the counter width needed to hold it.
  localparam int COUNT_MAX = DEBOUNCE_TIME_MS * 1_000_000 / CLK_PERIOD_NS;
  localparam int COUNT_W   = $clog2(COUNT_MAX + 1);

  localparam logic [COUNT_W-1:0] C_MAX  = COUNT_W'(COUNT_MAX);
  localparam logic [COUNT_W-1:0] C_LAST = COUNT_W'(COUNT_MAX - 1);
  localparam logic [COUNT_W-1:0] C_ONE  = COUNT_W'(1);

  // Synchroniser chain; r_prev is one cycle behind r_sync2 for change detection.
  logic               r_sync1;
  logic               r_sync2;
  logic               r_prev;

  // Stability counter and registered output.
  logic [COUNT_W-1:0] r_count;
  logic               r_clean;

  // Next-state values for the counter and output.
  logic [COUNT_W-1:0] w_count_next;
  logic               w_clean_next;
  logic               w_stable;

  // r_sync2 is the only place the raw input is consumed after synchronisation.
  assign w_stable = (r_sync2 == r_prev);

  // Synchronise the raw input and keep a one-cycle-delayed copy.
  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge value of its source; blocking here would collapse the chain.
  // NOTE: reset is synchronous, so it is only seen at a rising clk_in edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= bouncey_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Decide the next count and output: restart on change, count while stable,
  // publish the level on the last count, then saturate.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_count_next = r_count;
    w_clean_next = r_clean;
    if (!w_stable) begin
      w_count_next = '0;
    end else if (r_count < C_LAST) begin
      w_count_next = r_count + C_ONE;
    end else if (r_count == C_LAST) begin
      // Re-qualifying the current level rewrites the same value: no glitch.
      w_count_next = C_MAX;
      w_clean_next = r_sync2;
    end
  end

  // Register the counter and the debounced level; reset discards any partial count.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_count <= '0;
      r_clean <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_clean <= w_clean_next;
    end
  end

  assign clean_out = r_clean;

endmodule

// File: tb/tb_debounce.sv
`timescale 1ns / 1ps
// tb_debounce: scenario tasks drive the debouncer with a shortened qualification
// time (COUNT_MAX = 10) and compare clean_out every cycle against a queue of
// expected levels produced by a small timing model of the input history.
module tb_debounce;

  // 1 ms at a 100 us clock period gives a 10-cycle threshold.
  localparam int CLK_NS = 100_000;
  localparam int DB_MS  = 1;
  localparam int CM     = DB_MS * 1_000_000 / CLK_NS;
  localparam int LAT    = CM + 2;          // edges from first sample to output
  localparam int RUN_SAT = CM + 100;

  logic clk_in;
  logic rst_in;
  logic bouncey_in;
  logic clean_out;

  int n_err;
  int n_chk;

  // Expected-output model: a level held for LAT+1 consecutive samples appears
  // on clean_out after the edge of its (LAT+1)th sample. Stimulus keeps every
  // short run below CM so rejection is unambiguous.
  logic m_out;
  logic m_level;
  int   m_run;
  logic exp_q[$];

  debounce #(
    .CLK_PERIOD_NS   (CLK_NS),
    .DEBOUNCE_TIME_MS(DB_MS)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .bouncey_in(bouncey_in),
    .clean_out (clean_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Drive one cycle of stimulus, push the expected output, then step past the edge.
  task automatic drive_cycle(input logic v, input logic rst);
    bouncey_in = v;
    rst_in     = rst;
    if (rst) begin
      m_out   = 1'b0;
      m_level = 1'b0;
      m_run   = RUN_SAT;
    end else begin
      if (v === m_level) begin
        if (m_run < RUN_SAT) m_run++;
      end else begin
        m_level = v;
        m_run   = 1;
      end
      if (m_run == LAT + 1) m_out = v;
    end
    exp_q.push_back(m_out);
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    logic e;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b1);
      e = exp_q.pop_front();
      n_chk++;
      if (clean_out !== e) begin
        n_err++;
        $display("FAIL reset cyc=%0d clean_out=%b expected=%b", i, clean_out, e);
      end
      n_chk++;
      if (int'(dut.r_count) != 0) begin
        n_err++;
        $display("FAIL reset_count cyc=%0d count=%0d expected=0", i, dut.r_count);
      end
    end
  endtask

  task automatic test_idle();
    logic e;
    for (int i = 0; i < 2 * CM + 5; i++) begin
      drive_cycle(1'b0, 1'b0);
      e = exp_q.pop_front();
      n_chk++;
      if (clean_out !== e) begin
        n_err++;
        $display("FAIL idle cyc=%0d clean_out=%b expected=%b", i, clean_out, e);
      end
    end
    n_chk++;
    if (int'(dut.r_count) != CM) begin
      n_err++;
      $display("FAIL idle_saturate count=%0d expected=%0d", dut.r_count, CM);
    end
  endtask

  task automatic test_press();
    logic e;
    int   rise_edge;
    rise_edge = -1;
    for (int i = 0; i < 3 * CM; i++) begin
      drive_cycle(1'b1, 1'b0);
      e = exp_q.pop_front();
      n_chk++;
      if (clean_out !== e) begin
        n_err++;
        $display("FAIL press cyc=%0d clean_out=%b expected=%b", i, clean_out, e);
      end
      if (clean_out === 1'b1 && rise_edge < 0) rise_edge = i;
    end
    n_chk++;
    if (rise_edge != LAT) begin
      n_err++;
      $display("FAIL press_latency rose_at_edge=%0d expected=%0d", rise_edge, LAT);
    end
  endtask

  task automatic test_release();
    logic e;
    int   fall_edge;
    fall_edge = -1;
    for (int i = 0; i < 3 * CM; i++) begin
      drive_cycle(1'b0, 1'b0);
      e = exp_q.pop_front();
      n_chk++;
      if (clean_out !== e) begin
        n_err++;
        $display("FAIL release cyc=%0d clean_out=%b expected=%b", i, clean_out, e);
      end
      if (clean_out === 1'b0 && fall_edge < 0) fall_edge = i;
    end
    n_chk++;
    if (fall_edge != LAT) begin
      n_err++;
      $display("FAIL release_latency fell_at_edge=%0d expected=%0d", fall_edge, LAT);
    end
    // Second press must rise identically.
    for (int i = 0; i < 3 * CM; i++) begin
      drive_cycle(1'b1, 1'b0);
      e = exp_q.pop_front();
      n_chk++;
      if (clean_out !== e) begin
        n_err++;
        $display("FAIL repress cyc=%0d clean_out=%b expected=%b", i, clean_out, e);
      end
    end
  endtask

  task automatic test_bounce();
    logic e;
    logic seg[5];
    seg = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    // Return to a settled low first.
    for (int i = 0; i < 3 * CM; i++) begin
      drive_cycle(1'b0, 1'b0);
      e = exp_q.pop_front();
      n_chk++;
      if (clean_out !== e) begin
        n_err++;
        $display("FAIL bounce_settle cyc=%0d clean_out=%b expected=%b", i, clean_out, e);
      end
    end
    // Bouncing press: each segment shorter than the threshold, last one held.
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < ((s == 4) ? 3 * CM : CM / 2); i++) begin
        drive_cycle(seg[s], 1'b0);
        e = exp_q.pop_front();
        n_chk++;
        if (clean_out !== e) begin
          n_err++;
          $display("FAIL bounce seg=%0d cyc=%0d clean_out=%b expected=%b", s, i, clean_out, e);
        end
        if (s < 4 && clean_out !== 1'b0) begin
          n_err++;
          $display("FAIL bounce_early seg=%0d cyc=%0d clean_out=%b expected=0", s, i, clean_out);
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic e;
    int   plen[2];
    plen = '{CM - 1, 1};
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < plen[p] + 3 * CM; i++) begin
        drive_cycle((i < plen[p]) ? 1'b0 : 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_chk++;
        if (clean_out !== e || clean_out !== 1'b1) begin
          n_err++;
          $display("FAIL glitch len=%0d cyc=%0d clean_out=%b expected=%b", plen[p], i, clean_out, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic e;
    int   rise_edge;
    rise_edge = -1;
    for (int i = 0; i < 3 * CM + CM / 2; i++) begin
      drive_cycle((i < 3 * CM) ? 1'b0 : 1'b1, 1'b0);
      e = exp_q.pop_front();
      n_chk++;
      if (clean_out !== e) begin
        n_err++;
        $display("FAIL midreset_pre cyc=%0d clean_out=%b expected=%b", i, clean_out, e);
      end
    end
    drive_cycle(1'b1, 1'b1);
    e = exp_q.pop_front();
    n_chk++;
    if (clean_out !== e) begin
      n_err++;
      $display("FAIL midreset_edge clean_out=%b expected=%b", clean_out, e);
    end
    n_chk++;
    if (int'(dut.r_count) != 0) begin
      n_err++;
      $display("FAIL midreset_count count=%0d expected=0", dut.r_count);
    end
    for (int i = 0; i < 3 * CM; i++) begin
      drive_cycle(1'b1, 1'b0);
      e = exp_q.pop_front();
      n_chk++;
      if (clean_out !== e) begin
        n_err++;
        $display("FAIL midreset_post cyc=%0d clean_out=%b expected=%b", i, clean_out, e);
      end
      if (clean_out === 1'b1 && rise_edge < 0) rise_edge = i;
    end
    n_chk++;
    if (rise_edge != LAT) begin
      n_err++;
      $display("FAIL midreset_latency rose_at_edge=%0d expected=%0d", rise_edge, LAT);
    end
  endtask

  task automatic test_startup();
    logic e;
    // Reset with the input already high: output must start low and qualify fully.
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b1);
      e = exp_q.pop_front();
      n_chk++;
      if (clean_out !== e) begin
        n_err++;
        $display("FAIL startup_reset cyc=%0d clean_out=%b expected=%b", i, clean_out, e);
      end
    end
    for (int i = 0; i < 3 * CM; i++) begin
      drive_cycle(1'b1, 1'b0);
      e = exp_q.pop_front();
      n_chk++;
      if (clean_out !== e) begin
        n_err++;
        $display("FAIL startup cyc=%0d clean_out=%b expected=%b", i, clean_out, e);
      end
    end
  endtask

  initial begin
    n_err      = 0;
    n_chk      = 0;
    rst_in     = 1'b1;
    bouncey_in = 1'b0;
    m_out      = 1'b0;
    m_level    = 1'b0;
    m_run      = RUN_SAT;
    test_reset();
    test_idle();
    test_press();
    test_release();
    test_bounce();
    test_glitch();
    test_reset_mid();
    test_startup();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

endmodule
